// File: rtl/sm83_alu_nibble_seq.sv
// Two-pass nibble sequencer for the SM83 8-bit ALU: feeds the 4-bit carry-lookahead
// generator with the low nibble, then the high nibble, and assembles result and Z/N/H/C.
module sm83_alu_nibble_seq #(
    parameter bit ZERO_PG_ON_LOGIC = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cy_in,
    output logic [3:0] cg_p,
    output logic [3:0] cg_g,
    output logic       cg_cin,
    input  logic [3:0] cg_cout,
    output logic [7:0] result,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_h,
    output logic       flag_c,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    state_t     state, state_nxt;
    logic [7:0] a_r;
    logic [7:0] bx_r;
    logic [2:0] op_r;
    logic       cin0_r;
    logic       clo_msb;
    logic [3:0] sum_lo;

    logic       accept;
    logic       op_is_sub;
    logic       op_is_logic;
    logic       start_is_sub;
    logic       cin0_nxt;
    logic [3:0] sum_hi;
    logic [7:0] arith_val;
    logic [7:0] final_val;

    assign accept       = start && ((state == IDLE) || (state == DONE));
    assign busy         = (state == LO) || (state == HI);
    assign done         = (state == DONE);
    assign start_is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    assign op_is_sub    = (op_r == OP_SUB) || (op_r == OP_SBC) || (op_r == OP_CP);
    assign op_is_logic  = (op_r == OP_AND) || (op_r == OP_XOR) || (op_r == OP_OR);

    always_comb begin
        cin0_nxt = 1'b0;
        case (op)
            OP_ADC:       cin0_nxt = cy_in;
            OP_SUB, OP_CP: cin0_nxt = 1'b1;
            OP_SBC:       cin0_nxt = ~cy_in;
            default:      cin0_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LO : IDLE;
            LO:      state_nxt = HI;
            HI:      state_nxt = DONE;
            DONE:    state_nxt = start ? LO : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Generator drive: logic ops may leave the carry chain quiet.
    always_comb begin
        cg_p   = 4'h0;
        cg_g   = 4'h0;
        cg_cin = 1'b0;
        if (!(op_is_logic && ZERO_PG_ON_LOGIC)) begin
            case (state)
                LO: begin
                    cg_p   = a_r[3:0] | bx_r[3:0];
                    cg_g   = a_r[3:0] & bx_r[3:0];
                    cg_cin = cin0_r;
                end
                HI: begin
                    cg_p   = a_r[7:4] | bx_r[7:4];
                    cg_g   = a_r[7:4] & bx_r[7:4];
                    cg_cin = clo_msb;
                end
                default: begin
                    cg_p   = 4'h0;
                    cg_g   = 4'h0;
                    cg_cin = 1'b0;
                end
            endcase
        end
    end

    assign sum_hi    = a_r[7:4] ^ bx_r[7:4] ^ {cg_cout[2:0], clo_msb};
    assign arith_val = {sum_hi, sum_lo};

    always_comb begin
        final_val = arith_val;
        case (op_r)
            OP_AND:  final_val = a_r & bx_r;
            OP_XOR:  final_val = a_r ^ bx_r;
            OP_OR:   final_val = a_r | bx_r;
            default: final_val = arith_val;
        endcase
    end

    // Operand latch and the two nibble passes; result/flags commit on the HI->DONE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= 8'h00;
            bx_r    <= 8'h00;
            op_r    <= OP_ADD;
            cin0_r  <= 1'b0;
            clo_msb <= 1'b0;
            sum_lo  <= 4'h0;
            result  <= 8'h00;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (accept) begin
                a_r    <= a;
                bx_r   <= start_is_sub ? ~b : b;
                op_r   <= op;
                cin0_r <= cin0_nxt;
            end
            if (state == LO) begin
                clo_msb <= cg_cout[3];
                sum_lo  <= a_r[3:0] ^ bx_r[3:0] ^ {cg_cout[2:0], cin0_r};
            end
            if (state == HI) begin
                result <= (op_r == OP_CP) ? a_r : final_val;
                flag_z <= (final_val == 8'h00);
                flag_n <= op_is_sub;
                if (op_is_logic) begin
                    flag_h <= (op_r == OP_AND);
                    flag_c <= 1'b0;
                end else begin
                    flag_h <= clo_msb ^ op_is_sub;
                    flag_c <= cg_cout[3] ^ op_is_sub;
                end
            end
        end
    end

endmodule
